multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle RV32I core. It generalises the combinational opcode decoder into a sequenced controller.
- Adds JALR, LUI and AUIPC support, variable-latency memory handshake, a bounded wait timeout, illegal-opcode trap, retire pulse and retired-instruction counter.
- Sits between the instruction register (Opcode) and the shared-ALU/unified-memory datapath.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/multicycle_controller_if.sv | 27 ++
 rtl/ctrl_wait_timer.sv | 35 +++
 rtl/multicycle_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// Holds opcodes, the state enum and datapath mux/ALU/trap encodings.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_ALU_WB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified-memory request handshake between controller and memory.
// master: mem_req/MemRead/MemWrite/IorD out, mem_ready in.
interface multicycle_controller_if;

    logic mem_req;
    logic MemRead;
    logic MemWrite;
    logic IorD;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemRead,
        output MemWrite,
        output IorD,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemRead,
        input  MemWrite,
        input  IorD,
        output mem_ready
    );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: clear, waiting in; expired out.
// expired is high once MEM_TIMEOUT-1 wait cycles have elapsed.
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, reset, clear, waiting};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int TW =
                (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [TW-1:0] cnt;

            assign expired = (cnt == TW'(MEM_TIMEOUT - 1));

            // Holds at the limit; the FSM leaves the state anyway.
            always_ff @(posedge clk) begin
                if (reset || clear)
                    cnt <= '0;
                else if (waiting && !expired)
                    cnt <= cnt + TW'(1);
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Sequenced main control FSM for the multi-cycle RV32I core.
// In: clk, reset, Opcode, mem.mem_ready. Out: datapath controls,
// memory request, retire/instr_count and sticky trap/trap_cause.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    multicycle_controller_if.master mem,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic                retire,
    output logic [CNT_W-1:0]    instr_count,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    state_t     state;
    state_t     nxt;
    logic [1:0] nxt_cause;
    logic       req;
    logic       rd;
    logic       wr;
    logic       iord;
    logic       ready;
    logic       expired;

    assign ready        = mem.mem_ready;
    assign mem.mem_req  = req;
    assign mem.MemRead  = rd;
    assign mem.MemWrite = wr;
    assign mem.IorD     = iord;

    ctrl_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (nxt != state),
        .waiting(req && !ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_RST;
        else
            state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else if (state != S_TRAP && nxt == S_TRAP) begin
            trap       <= 1'b1;
            trap_cause <= nxt_cause;
        end
    end

    always_comb begin
        nxt         = state;
        nxt_cause   = CAUSE_NONE;
        req         = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        iord        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        MemtoReg    = WB_ALUOUT;
        RegWrite    = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                req     = 1'b1;
                rd      = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = ready;
                PCWrite = ready;
                // ready wins over a same-cycle timeout
                if (ready) begin
                    nxt = S_DECODE;
                end else if (expired) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                unique case (1'b1)
                    (Opcode == OPCODE_W'(OP_LOAD)),
                    (Opcode == OPCODE_W'(OP_STORE)):
                        nxt = S_MEM_ADDR;
                    (Opcode == OPCODE_W'(OP_OP)):
                        nxt = S_EXEC_R;
                    (Opcode == OPCODE_W'(OP_IMM)):
                        nxt = S_EXEC_I;
                    (Opcode == OPCODE_W'(OP_LUI)):
                        nxt = S_EXEC_LUI;
                    (Opcode == OPCODE_W'(OP_AUIPC)):
                        nxt = S_ALU_WB;
                    (Opcode == OPCODE_W'(OP_BRANCH)):
                        nxt = S_BRANCH;
                    (Opcode == OPCODE_W'(OP_JAL)):
                        nxt = S_JAL;
                    (Opcode == OPCODE_W'(OP_JALR)):
                        nxt = S_JALR;
                    default: begin
                        nxt       = S_TRAP;
                        nxt_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                nxt = (Opcode == OPCODE_W'(OP_LOAD)) ?
                      S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                req  = 1'b1;
                rd   = 1'b1;
                iord = 1'b1;
                if (ready) begin
                    nxt = S_MEM_WB;
                end else if (expired) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = WB_MDR;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEM_WR: begin
                req    = 1'b1;
                wr     = 1'b1;
                iord   = 1'b1;
                retire = ready;
                if (ready) begin
                    nxt = S_FETCH;
                end else if (expired) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
                nxt     = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                nxt     = S_ALU_WB;
            end
            S_EXEC_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                nxt     = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                MemtoReg = WB_ALUOUT;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_RS1;
                ALUSrcB     = SRCB_RS2;
                ALUOp       = ALUOP_BR;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                retire      = 1'b1;
                nxt         = S_FETCH;
            end
            S_JALR: begin
                // Target rs1+imm lands in ALUOut, then JAL links
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                nxt     = S_JAL;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALUOP_PASS;
                MemtoReg = WB_ALU;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = PCSRC_ALUOUT;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller.
// dut: MEM_TIMEOUT=4, CNT_W=32; dut2: MEM_TIMEOUT=0, CNT_W=2.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       rdy = 1'b1;

    always #5 clk = ~clk;

    multicycle_controller_if mif ();
    multicycle_controller_if mif2 ();
    assign mif.mem_ready  = rdy;
    assign mif2.mem_ready = rdy;

    logic        irw, pcw, pcwc, rw, ret, trp;
    logic [1:0]  pcs, sa, sb, aop, m2r, cause;
    logic [31:0] cnt;
    logic        irw2, pcw2, pcwc2, rw2, ret2, trp2;
    logic [1:0]  pcs2, sa2, sb2, aop2, m2r2, cause2;
    logic [1:0]  cnt2;

    multicycle_controller #(
        .OPCODE_W(7), .MEM_TIMEOUT(4), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .Opcode(opcode), .mem(mif),
        .IRWrite(irw), .PCWrite(pcw), .PCWriteCond(pcwc),
        .PCSource(pcs), .ALUSrcA(sa), .ALUSrcB(sb),
        .ALUOp(aop), .MemtoReg(m2r), .RegWrite(rw),
        .retire(ret), .instr_count(cnt), .trap(trp),
        .trap_cause(cause)
    );

    multicycle_controller #(
        .OPCODE_W(7), .MEM_TIMEOUT(0), .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .Opcode(opcode), .mem(mif2),
        .IRWrite(irw2), .PCWrite(pcw2), .PCWriteCond(pcwc2),
        .PCSource(pcs2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .ALUOp(aop2), .MemtoReg(m2r2), .RegWrite(rw2),
        .retire(ret2), .instr_count(cnt2), .trap(trp2),
        .trap_cause(cause2)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [19:0] ctl;
        int          cnt;
        int          cause;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCWriteCond,
    //  PCSource,ALUSrcA,ALUSrcB,ALUOp,MemtoReg,RegWrite,retire,trap}
    function automatic logic [19:0] cv(
        input int mreq, input int mrd, input int mwr, input int iord,
        input int ir, input int pw, input int pwc, input int ps,
        input int a, input int b, input int op, input int wb,
        input int w, input int r, input int t);
        return {1'(mreq), 1'(mrd), 1'(mwr), 1'(iord), 1'(ir),
                1'(pw), 1'(pwc), 2'(ps), 2'(a), 2'(b), 2'(op),
                2'(wb), 1'(w), 1'(r), 1'(t)};
    endfunction

    function automatic logic [19:0] got1();
        return {mif.mem_req, mif.MemRead, mif.MemWrite, mif.IorD,
                irw, pcw, pcwc, pcs, sa, sb, aop, m2r, rw, ret, trp};
    endfunction

    function automatic logic [19:0] got2();
        return {mif2.mem_req, mif2.MemRead, mif2.MemWrite,
                mif2.IorD, irw2, pcw2, pcwc2, pcs2, sa2, sb2,
                aop2, m2r2, rw2, ret2, trp2};
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", nm, row, got, exp);
        end
    endtask

    task automatic add(input int r, input logic [6:0] op, input int rd,
                       input logic [19:0] c, input int n, input int cs);
        tbl.push_back('{1'(r), op, 1'(rd), c, n, cs});
    endtask

    logic [19:0] RSTV, FR, FW, DEC, MADR, MRD, MWB, MWRR, MWRW;
    logic [19:0] EXR, EXI, LUI, AWB, BR, JL, TRP;
    logic [6:0]  ADD_OP, LW_OP, SW_OP;

    initial begin
        RSTV = '0;
        FR   = cv(1,1,0,0,1,1,0, 0,0,1,0,0, 0,0,0);
        FW   = cv(1,1,0,0,0,0,0, 0,0,1,0,0, 0,0,0);
        DEC  = cv(0,0,0,0,0,0,0, 0,1,2,0,0, 0,0,0);
        MADR = cv(0,0,0,0,0,0,0, 0,2,2,0,0, 0,0,0);
        MRD  = cv(1,1,0,1,0,0,0, 0,0,0,0,0, 0,0,0);
        MWB  = cv(0,0,0,0,0,0,0, 0,0,0,0,1, 1,1,0);
        MWRR = cv(1,0,1,1,0,0,0, 0,0,0,0,0, 0,1,0);
        MWRW = cv(1,0,1,1,0,0,0, 0,0,0,0,0, 0,0,0);
        EXR  = cv(0,0,0,0,0,0,0, 0,2,0,2,0, 0,0,0);
        EXI  = cv(0,0,0,0,0,0,0, 0,2,2,2,0, 0,0,0);
        LUI  = cv(0,0,0,0,0,0,0, 0,3,2,0,0, 0,0,0);
        AWB  = cv(0,0,0,0,0,0,0, 0,0,0,0,0, 1,1,0);
        BR   = cv(0,0,0,0,0,0,1, 1,2,0,1,0, 0,1,0);
        JL   = cv(0,0,0,0,0,1,0, 1,1,1,3,2, 1,1,0);
        TRP  = cv(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,1);
        ADD_OP = 7'b0110011;
        LW_OP  = 7'b0000011;
        SW_OP  = 7'b0100011;

        for (int i = 0; i < 3; i++) add(1, 0, 1, RSTV, 0, 0);
        add(0, 0, 1, RSTV, 0, 0);
        add(0, 0, 1, FR, 0, 0);
        add(0, ADD_OP, 1, DEC, 0, 0);
        add(0, 0, 1, EXR, 0, 0);
        add(0, 0, 1, AWB, 0, 0);
        add(0, 0, 1, FR, 1, 0);
        add(0, LW_OP, 1, DEC, 1, 0);
        add(0, LW_OP, 1, MADR, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, MRD, 1, 0);
        add(0, 0, 1, MRD, 1, 0);
        add(0, 0, 1, MWB, 1, 0);
        add(0, 0, 1, FR, 2, 0);
        add(0, SW_OP, 1, DEC, 2, 0);
        add(0, SW_OP, 1, MADR, 2, 0);
        add(0, 0, 0, MWRW, 2, 0);
        add(0, 0, 1, MWRR, 2, 0);
        add(0, 0, 1, FR, 3, 0);
        add(0, 7'b1100111, 1, DEC, 3, 0);
        add(0, 0, 1, MADR, 3, 0);
        add(0, 0, 1, JL, 3, 0);
        add(0, 0, 1, FR, 4, 0);
        add(0, 7'b1100011, 1, DEC, 4, 0);
        add(0, 0, 1, BR, 4, 0);
        add(0, 0, 1, FR, 5, 0);
        add(0, 7'b0110111, 1, DEC, 5, 0);
        add(0, 0, 1, LUI, 5, 0);
        add(0, 0, 1, AWB, 5, 0);
        add(0, 0, 1, FR, 6, 0);
        add(0, 7'b0010111, 1, DEC, 6, 0);
        add(0, 0, 1, AWB, 6, 0);
        add(0, 0, 1, FR, 7, 0);
        add(0, 7'b0010011, 1, DEC, 7, 0);
        add(0, 0, 1, EXI, 7, 0);
        add(0, 0, 1, AWB, 7, 0);
        add(0, 0, 1, FR, 8, 0);
        add(0, 7'b1101111, 1, DEC, 8, 0);
        add(0, 0, 1, JL, 8, 0);
        add(0, 0, 1, FR, 9, 0);
        add(0, 7'b1111111, 1, DEC, 9, 0);
        for (int i = 0; i < 10; i++) add(0, ADD_OP, 1, TRP, 9, 1);
        add(1, 0, 1, TRP, 9, 1);
        add(1, 0, 1, RSTV, 0, 0);
        add(0, 0, 0, RSTV, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, FW, 0, 0);
        add(0, 0, 0, TRP, 0, 2);
        add(1, 0, 0, TRP, 0, 2);
        add(0, 0, 0, RSTV, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, FW, 0, 0);
        add(0, 0, 1, FR, 0, 0);
        add(0, ADD_OP, 1, DEC, 0, 0);
        add(0, 0, 1, EXR, 0, 0);
        add(0, 0, 1, AWB, 0, 0);
        add(0, 0, 0, FW, 1, 0);
        add(1, 0, 0, FW, 1, 0);
        add(0, 0, 0, RSTV, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset  = tbl[i].rst;
            opcode = tbl[i].op;
            rdy    = tbl[i].rdy;
            #1;
            chk("ctl", i, 32'(got1()), 32'(tbl[i].ctl));
            chk("count", i, cnt, 32'(tbl[i].cnt));
            chk("cause", i, 32'(cause), 32'(tbl[i].cause));
            chk("count2", i, 32'(cnt2), 32'(tbl[i].cnt % 4));
        end

        // Long stall in FETCH: the timeout-disabled instance
        // keeps requesting while the other one traps.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            chk("no_timeout_ctl2", i, 32'(got2()), 32'(FW));
        end
        chk("stall_trap", 0, 32'(trp), 32'd1);
        chk("stall_cause", 0, 32'(cause), 32'd2);
        chk("stall_cause2", 0, 32'(cause2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
